filter_conv_pipe: RTL

FILTER_CONV_PIPE -- requirements
Module: filter_conv_pipe

---
 rtl/filter_conv_pipe.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/filter_conv_pipe.sv
// Three-stage 2-D convolution pipeline: multiply, adder tree, then abs/normalise/saturate.
// A single advance enable stalls all stages together when the output is blocked.
module filter_conv_pipe #(
  parameter int p_data_bw  = 10,
  parameter int p_win_size = 9,
  parameter int p_coef_bw  = 5
) (
  input  logic                              i_clk,
  input  logic                              i_rstn,
  input  logic [2:0]                        i_mode,
  input  logic [4:0]                        i_user_shift,
  input  logic                              i_coef_wr_en,
  input  logic [$clog2(p_win_size)-1:0]     i_coef_wr_addr,
  input  logic [p_coef_bw-1:0]              i_coef_wr_data,
  input  logic                              i_dxi_in_valid,
  output logic                              o_dxi_in_ready,
  input  logic [p_data_bw*p_win_size-1:0]   i_dxi_in_data,
  output logic [p_data_bw-1:0]              o_dxi_out_data,
  output logic                              o_dxi_out_valid,
  input  logic                              i_dxi_out_ready,
  output logic                              o_sat_flag,
  input  logic                              i_sat_clr,
  output logic [15:0]                       o_pix_count
);

  localparam int AW = $clog2(p_win_size);
  localparam int PW = p_data_bw + p_coef_bw + 1;
  localparam int SW = PW + AW;
  localparam int NW = SW + 3;
  localparam bit BUILTIN_OK = (p_win_size == 32'sd9);
  localparam logic [AW:0] WIN_CNT = (AW + 1)'(p_win_size);
  localparam logic [NW-1:0] MAX_VAL = {{(NW - p_data_bw){1'b0}}, {p_data_bw{1'b1}}};

  function automatic logic signed [4:0] kernel_coef(input logic [2:0] mode, input logic [4:0] idx);
    logic signed [4:0] k;
    k = 5'sd0;
    case (mode)
      3'd0: begin
        case (idx)
          5'd4:                   k = 5'sd4;
          5'd1, 5'd3, 5'd5, 5'd7: k = -5'sd1;
          default:                k = 5'sd0;
        endcase
      end
      3'd1: begin
        if (idx == 5'd4) k = 5'sd8;
        else             k = -5'sd1;
      end
      3'd2: begin
        case (idx)
          5'd4:                   k = 5'sd4;
          5'd1, 5'd3, 5'd5, 5'd7: k = 5'sd2;
          default:                k = 5'sd1;
        endcase
      end
      3'd3:    k = 5'sd1;
      default: k = 5'sd0;
    endcase
    return k;
  endfunction

  logic                       en_s;
  logic [2:0]                 mode_eff_s;
  logic                       coef_wr_ok_s;
  logic [p_coef_bw-1:0]       user_coef_r [p_win_size];
  logic signed [PW-1:0]       prod_s [p_win_size];
  logic signed [PW-1:0]       prod_r [p_win_size];
  logic [2:0]                 s1_mode_r, s2_mode_r;
  logic [4:0]                 s1_shift_r, s2_shift_r;
  logic                       s1_valid_r, s2_valid_r, s3_valid_r;
  logic signed [SW-1:0]       sum_s, sum_r;
  logic [SW-1:0]              abs_s;
  logic [NW-1:0]              abs_ext_s, norm_s;
  logic                       sat_s;
  logic [p_data_bw-1:0]       res_s;
  logic [p_data_bw-1:0]       out_data_r;
  logic                       sat_flag_r;
  logic [15:0]                pix_count_r;

  assign en_s            = !s3_valid_r || i_dxi_out_ready;
  assign o_dxi_in_ready  = en_s;
  assign o_dxi_out_data  = out_data_r;
  assign o_dxi_out_valid = s3_valid_r;
  assign o_sat_flag      = sat_flag_r;
  assign o_pix_count     = pix_count_r;
  assign coef_wr_ok_s    = i_coef_wr_en && ({1'b0, i_coef_wr_addr} < WIN_CNT);

  // Built-in kernels exist only for 3x3 windows; everything else falls back to user coefficients.
  always_comb begin
    if (!BUILTIN_OK || i_mode > 3'd4) mode_eff_s = 3'd4;
    else                              mode_eff_s = i_mode;
  end

  for (genvar g = 0; g < p_win_size; g++) begin : g_tap
    logic signed [4:0]    kc_s;
    logic signed [PW-1:0] coef_s, pix_s;
    assign kc_s   = kernel_coef(mode_eff_s, 5'(g));
    assign pix_s  = $signed({{(PW - p_data_bw){1'b0}}, i_dxi_in_data[g*p_data_bw +: p_data_bw]});
    assign coef_s = (mode_eff_s == 3'd4)
                  ? {{(PW - p_coef_bw){user_coef_r[g][p_coef_bw-1]}}, user_coef_r[g]}
                  : {{(PW - 5){kc_s[4]}}, kc_s};
    assign prod_s[g] = pix_s * coef_s;
  end

  // User coefficient bank; out-of-range writes are dropped.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < p_win_size; i++) user_coef_r[i] <= {p_coef_bw{1'b0}};
    end else if (coef_wr_ok_s) begin
      user_coef_r[i_coef_wr_addr] <= i_coef_wr_data;
    end
  end

  // Stage 1: products, with mode and shift captured at accept.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < p_win_size; i++) prod_r[i] <= {PW{1'b0}};
      s1_mode_r  <= 3'd0;
      s1_shift_r <= 5'd0;
      s1_valid_r <= 1'b0;
    end else if (en_s) begin
      for (int i = 0; i < p_win_size; i++) prod_r[i] <= prod_s[i];
      s1_mode_r  <= mode_eff_s;
      s1_shift_r <= i_user_shift;
      s1_valid_r <= i_dxi_in_valid;
    end
  end

  // Adder tree, sign-extended so no partial sum can overflow.
  always_comb begin
    sum_s = {SW{1'b0}};
    for (int i = 0; i < p_win_size; i++) begin
      sum_s = sum_s + {{(SW - PW){prod_r[i][PW-1]}}, prod_r[i]};
    end
  end

  // Stage 2: sum register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sum_r      <= {SW{1'b0}};
      s2_mode_r  <= 3'd0;
      s2_shift_r <= 5'd0;
      s2_valid_r <= 1'b0;
    end else if (en_s) begin
      sum_r      <= sum_s;
      s2_mode_r  <= s1_mode_r;
      s2_shift_r <= s1_shift_r;
      s2_valid_r <= s1_valid_r;
    end
  end

  assign abs_s     = sum_r[SW-1] ? (~sum_r + {{(SW - 1){1'b0}}, 1'b1}) : sum_r;
  assign abs_ext_s = {3'b000, abs_s};

  // Smoothing kernels never go negative, so the magnitude equals S for them.
  always_comb begin
    case (s2_mode_r)
      3'd0:    norm_s = abs_ext_s >> 2;
      3'd1:    norm_s = abs_ext_s >> 3;
      3'd2:    norm_s = abs_ext_s >> 4;
      3'd3:    norm_s = ((abs_ext_s << 3) - abs_ext_s) >> 6;
      default: norm_s = abs_ext_s >> s2_shift_r;
    endcase
  end

  assign sat_s = (norm_s > MAX_VAL);
  assign res_s = sat_s ? {p_data_bw{1'b1}} : norm_s[p_data_bw-1:0];

  // Stage 3: output register, sticky saturation and transfer counter.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      out_data_r  <= {p_data_bw{1'b0}};
      s3_valid_r  <= 1'b0;
      sat_flag_r  <= 1'b0;
      pix_count_r <= 16'd0;
    end else begin
      if (en_s) begin
        out_data_r <= res_s;
        s3_valid_r <= s2_valid_r;
      end
      if (en_s && s2_valid_r && sat_s) sat_flag_r <= 1'b1;
      else if (i_sat_clr)              sat_flag_r <= 1'b0;
      if (s3_valid_r && i_dxi_out_ready) pix_count_r <= pix_count_r + 16'd1;
    end
  end

endmodule
